shift_univ: RTL and testbench
=============================

// Module: shift_univ
// PURPOSE
//  Parametrised universal shift register: WIDTH-bit, hold / shift-right / shift-left / parallel load,
//  optional rotate, serial in/out and a frame counter that flags every WIDTH completed shifts.
//  Serves as the serial<->parallel converter for the digital_fundamentals examples (UART/SPI-style
//  deserialise, LED chasers, accumulator operand feed); supersedes the fixed 4-bit right shifter.
// PARAMETERS
//  WIDTH    8   register width in bits; legal range 2..32
//  RST_VAL  0   value loaded into the data register on reset (WIDTH bits)
//  CNT_W    $clog2(WIDTH)  localparam, frame counter width; not overridable
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      reset, asynchronous, active-high
//  en          in   1      clock enable; 0 = hold regardless of mode
//  mode        in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//  rot         in   1      1 = rotate: fill bit is the bit shifted out, sin ignored
//  sin         in   1      serial data in
//  pin         in   WIDTH  parallel load data
//  pout        out  WIDTH  register contents (registered)
//  sout        out  1      serial out: pout[WIDTH-1] when mode==10, else pout[0] (combinational from reg)
//  frame_done  out  1      one-cycle pulse, WIDTH shifts completed since last load/reset/frame
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): pout=RST_VAL, cnt=0, frame_done=0 immediately; sout follows pout.
//  - Action taken at rising clk only when en=1; en=0 -> pout, cnt unchanged, frame_done=0.
//  - Shift right (01): pout <= {fill, pout[WIDTH-1:1]}; fill = rot ? pout[0] : sin. First bit in ends at LSB.
//  - Shift left  (10): pout <= {pout[WIDTH-2:0], fill}; fill = rot ? pout[WIDTH-1] : sin.
//  - Load (11): pout <= pin, cnt <= 0, frame_done <= 0; rot/sin ignored.
//  - Hold (00): no change to pout or cnt; frame_done <= 0.
//  - cnt counts enabled shifts 0..WIDTH-1. On a shift with cnt==WIDTH-1: cnt wraps to 0 and
//    frame_done <= 1 at the same edge, i.e. high in the cycle pout shows the WIDTH-th shifted value.
//    Any other edge: frame_done <= 0. Never high two cycles running unless WIDTH shifts occurred.
//  - Direction change mid-frame does not reset cnt; rot toggling mid-frame does not reset cnt.
//  - Latency: parallel load and each shift visible on pout one clk after the enabling edge.
//  - Rotate for WIDTH shifts returns the original pout value.
// STRUCTURE
//  - Package shift_pkg: mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10,
//    MODE_LOAD=2'b11; shared by shift_univ and its users.
//  - Sub-module shift_frame_cnt (WIDTH param): cnt register, wrap detect, frame_done register;
//    inputs clk, rst, en, shift (mode is 01/10), clr (load). Data path stays in shift_univ.
// TESTING (WIDTH=8, RST_VAL=0 unless stated)
//  1. rst=1 with en=1, mode=11, pin=0xFF -> pout=0x00, frame_done=0; release -> load takes next edge.
//  2. mode=01, rot=0, sin=1,0,1,1,0,0,1,0 over 8 en cycles -> pout=0x4D; frame_done=1 only in cycle after 8th edge.
//  3. load 0xA5, then mode=10, rot=1 for 8 cycles -> sout before each edge 1,0,1,0,0,1,0,1; pout returns 0xA5; one frame_done pulse.
//  4. 3 right shifts, then load 0x3C -> cnt cleared, no frame_done; pulse only after 8 further shifts.
//  5. en=0 with mode=01 for 5 cycles -> pout and cnt frozen, frame_done=0; resume completes frame at correct count.
//  6. rst asserted between edges after 5 shifts, RST_VAL=0x81 build -> pout=0x81 without a clock edge, next frame needs 8 shifts.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encodings for the universal shift register and its users.
package shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame counter: counts enabled shifts and pulses frame_done on every WIDTH-th one.
module shift_frame_cnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift,
  input  logic clr,
  output logic frame_done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        if (clr) begin
          cnt <= '0;
        end else if (shift) begin
          if (cnt == CNT_MAX) begin
            cnt        <= '0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/shift_univ.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / load,
// optional rotate, serial in/out and a frame-complete pulse every WIDTH shifts.
module shift_univ
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             frame_done
);

  logic             fill;
  logic [WIDTH-1:0] pout_next;
  logic             shift;
  logic             clr;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    fill      = sin;
    pout_next = pout;
    case (mode)
      MODE_SHR: begin
        fill      = rot ? pout[0] : sin;
        pout_next = {fill, pout[WIDTH-1:1]};
      end
      MODE_SHL: begin
        fill      = rot ? pout[WIDTH-1] : sin;
        pout_next = {pout[WIDTH-2:0], fill};
      end
      MODE_LOAD: pout_next = pin;
      MODE_HOLD: pout_next = pout;
      default:   pout_next = pout;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout <= RST_VAL;
    end else if (en) begin
      pout <= pout_next;
    end
  end

  // Serial out is the bit that the current direction would push out next.
  assign sout  = (mode == MODE_SHL) ? pout[WIDTH-1] : pout[0];
  assign shift = (mode == MODE_SHR) || (mode == MODE_SHL);
  assign clr   = (mode == MODE_LOAD);

  shift_frame_cnt #(
    .WIDTH(WIDTH)
  ) u_frame_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .shift     (shift),
    .clr       (clr),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_shift_univ.sv
// Randomised and directed bench for shift_univ against an arithmetic reference model.
module tb_shift_univ;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         rot;
  logic         sin;
  logic [W-1:0] pin;
  logic [W-1:0] pout_a, pout_b;
  logic         sout_a, sout_b;
  logic         fd_a, fd_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two register images (reset values 0x00 and 0x81) and
  // the number of shifts since the last load/reset/frame.
  int mp[2];
  int nsh;
  int mfd;

  always #5 clk = ~clk;

  shift_univ #(.WIDTH(W), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sin(sin), .pin(pin),
    .pout(pout_a), .sout(sout_a), .frame_done(fd_a)
  );

  shift_univ #(.WIDTH(W), .RST_VAL(8'h81)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot), .sin(sin), .pin(pin),
    .pout(pout_b), .sout(sout_b), .frame_done(fd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_sout(input int p, input logic [1:0] m);
    return (m == 2'b10) ? ((p >> (W - 1)) & 1) : (p & 1);
  endfunction

  task automatic model_reset();
    mp[0] = 'h00;
    mp[1] = 'h81;
    nsh   = 0;
    mfd   = 0;
  endtask

  task automatic model_edge(input logic e, input logic [1:0] m, input logic r,
                            input logic s, input logic [W-1:0] p);
    int fill;
    mfd = 0;
    if (!e) return;
    for (int k = 0; k < 2; k++) begin
      case (m)
        2'b01: begin
          fill  = r ? (mp[k] & 1) : int'(s);
          mp[k] = (mp[k] >> 1) + fill * (1 << (W - 1));
        end
        2'b10: begin
          fill  = r ? ((mp[k] >> (W - 1)) & 1) : int'(s);
          mp[k] = ((mp[k] * 2) + fill) % (1 << W);
        end
        2'b11: mp[k] = int'(p);
        default: ;
      endcase
    end
    if (m == 2'b11) begin
      nsh = 0;
    end else if (m != 2'b00) begin
      nsh++;
      if (nsh == W) begin
        nsh = 0;
        mfd = 1;
      end
    end
  endtask

  // Entered just after a rising edge: drive, check serial out before the
  // edge, then check registered outputs just after it.
  task automatic step(input logic e, input logic [1:0] m, input logic r,
                      input logic s, input logic [W-1:0] p);
    en = e; mode = m; rot = r; sin = s; pin = p;
    #1;
    check("sout_a_pre", 32'(sout_a), 32'(exp_sout(mp[0], m)));
    check("sout_b_pre", 32'(sout_b), 32'(exp_sout(mp[1], m)));
    @(posedge clk);
    model_edge(e, m, r, s, p);
    #1;
    check("pout_a", 32'(pout_a), 32'(mp[0]));
    check("pout_b", 32'(pout_b), 32'(mp[1]));
    check("frame_done_a", 32'(fd_a), 32'(mfd));
    check("frame_done_b", 32'(fd_b), 32'(mfd));
  endtask

  initial begin
    logic [W-1:0] sin_seq;
    int pulses;

    // 1: reset dominates a pending load
    rst = 1'b1; en = 1'b1; mode = 2'b11; rot = 1'b0; sin = 1'b0; pin = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pout_a", 32'(pout_a), 32'h00);
    check("rst_pout_b", 32'(pout_b), 32'h81);
    check("rst_fd_a", 32'(fd_a), 32'h0);
    rst = 1'b0;
    step(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
    check("load_after_rst", 32'(pout_a), 32'hFF);

    // 2: deserialise 1,0,1,1,0,0,1,0 LSB-last-in-at-top
    step(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
    sin_seq = 8'b0100_1101;
    pulses  = 0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, 2'b01, 1'b0, sin_seq[i], 8'h00);
      pulses += int'(fd_a);
    end
    check("deser_value", 32'(pout_a), 32'h4D);
    check("deser_fd_last", 32'(fd_a), 32'h1);
    check("deser_pulses", 32'(pulses), 32'd1);
    step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    check("deser_fd_drop", 32'(fd_a), 32'h0);

    // 3: rotate left a full frame returns the loaded value
    step(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < W; i++) step(1'b1, 2'b10, 1'b1, 1'b0, 8'h00);
    check("rotate_return", 32'(pout_a), 32'hA5);
    check("rotate_fd", 32'(fd_a), 32'h1);

    // 4: load mid-frame restarts the count
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
    step(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
    for (int i = 0; i < W; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    check("reload_fd_after_8", 32'(fd_a), 32'h1);

    // 5: disabled cycles freeze everything
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    check("en_resume_fd", 32'(fd_a), 32'h1);

    // 6: asynchronous reset between edges mid-frame
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_pout_a", 32'(pout_a), 32'h00);
    check("async_pout_b", 32'(pout_b), 32'h81);
    check("async_sout_b", 32'(sout_b), 32'h1);
    check("async_fd", 32'(fd_b), 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
    #1;
    check("post_rst_pout_b", 32'(pout_b), 32'(mp[1]));
    for (int i = 0; i < W - 1; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    check("post_rst_frame", 32'(fd_b), 32'h1);

    // Random phase: mostly enabled, all modes, rotate and serial data mixed
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
